king_scan_sequencer: RTL

Time-multiplexed controller that evaluates one king's safety using a single shared `checkCheck`/`checkAllow` probe pair, replacing eighteen parallel checker instances. When `start` is pulsed it probes the king's own square, then each on-board neighbour square in a fixed order, and collects the results into an escape mask. It then issues a SAFE/CHECK/CHECKMATE/STALEMATE verdict. It sits between the game FSM, which issues `start` once per half-move, and the shared probe datapath.

---
 rtl/king_scan_sequencer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/king_scan_sequencer.sv
`default_nettype none
// ============================================================================
// king_scan_sequencer
//   Scans a king's own square and each on-board neighbour through one shared
//   check/allow probe, then reports SAFE / CHECK / CHECKMATE / STALEMATE.
//   Revision: 1.0
// ============================================================================
module king_scan_sequencer #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        side,
    input  logic [5:0]  kingPosition,
    input  logic        otherMoves,
    output logic        probe_req,
    output logic [13:0] probe_move,
    input  logic        probe_ack,
    input  logic        probe_inCheck,
    input  logic        probe_allow,
    output logic        busy,
    output logic        done,
    output logic [1:0]  verdict,
    output logic        inCheck,
    output logic [7:0]  escapeMask,
    output logic        timeoutErr
);
    localparam int               CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SELF = 3'd1;
    localparam logic [2:0] S_NEXT = 3'd2;
    localparam logic [2:0] S_REQ  = 3'd3;
    localparam logic [2:0] S_EVAL = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [1:0] V_SAFE      = 2'b00;
    localparam logic [1:0] V_CHECK     = 2'b01;
    localparam logic [1:0] V_CHECKMATE = 2'b10;
    localparam logic [1:0] V_STALEMATE = 2'b11;

    logic [2:0]       state_q, state_d;
    logic [2:0]       dir_q, dir_d;
    logic             side_q, side_d;
    logic [5:0]       king_q, king_d;
    logic [7:0]       mask_q, mask_d;
    logic             in_check_q, in_check_d;
    logic [1:0]       verdict_q, verdict_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0] w_dest_file, w_dest_rank;
    logic       w_on_board;
    logic       w_blocked;

    // Edge tests are done on the 3-bit coordinates so a wrapped sum never probes.
    always_comb begin
        w_dest_file = king_q[5:3];
        w_dest_rank = king_q[2:0];
        w_on_board  = 1'b1;
        case (dir_q)
            3'd0, 3'd3, 3'd5: begin
                w_on_board  = (king_q[5:3] != 3'd0);
                w_dest_file = king_q[5:3] - 3'd1;
            end
            3'd2, 3'd4, 3'd7: begin
                w_on_board  = (king_q[5:3] != 3'd7);
                w_dest_file = king_q[5:3] + 3'd1;
            end
            default: ;
        endcase
        case (dir_q)
            3'd0, 3'd1, 3'd2: begin
                w_on_board  = w_on_board & (king_q[2:0] != 3'd0);
                w_dest_rank = king_q[2:0] - 3'd1;
            end
            3'd5, 3'd6, 3'd7: begin
                w_on_board  = w_on_board & (king_q[2:0] != 3'd7);
                w_dest_rank = king_q[2:0] + 3'd1;
            end
            default: ;
        endcase
    end

    assign w_blocked = (mask_q == 8'h00) & ~otherMoves;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            dir_q      <= 3'd0;
            side_q     <= 1'b0;
            king_q     <= 6'd0;
            mask_q     <= 8'h00;
            in_check_q <= 1'b0;
            verdict_q  <= V_SAFE;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            side_q     <= side_d;
            king_q     <= king_d;
            mask_q     <= mask_d;
            in_check_q <= in_check_d;
            verdict_q  <= verdict_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        side_d     = side_q;
        king_d     = king_q;
        mask_d     = mask_q;
        in_check_d = in_check_q;
        verdict_d  = verdict_q;
        timeout_d  = timeout_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    side_d     = side;
                    king_d     = kingPosition;
                    mask_d     = 8'h00;
                    in_check_d = 1'b0;
                    timeout_d  = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_SELF;
                end
            end
            S_SELF: begin
                if (probe_ack) begin
                    in_check_d = probe_inCheck;
                    dir_d      = 3'd0;
                    state_d    = S_NEXT;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    verdict_d = V_SAFE;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_NEXT: begin
                if (w_on_board) begin
                    cnt_d   = '0;
                    state_d = S_REQ;
                end else if (dir_q == 3'd7) begin
                    state_d = S_EVAL;
                end else begin
                    dir_d = dir_q + 3'd1;
                end
            end
            S_REQ: begin
                if (probe_ack) begin
                    mask_d[dir_q] = probe_allow & ~probe_inCheck;
                    if (dir_q == 3'd7) begin
                        state_d = S_EVAL;
                    end else begin
                        dir_d   = dir_q + 3'd1;
                        state_d = S_NEXT;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    verdict_d = V_SAFE;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EVAL: begin
                if (in_check_q) verdict_d = w_blocked ? V_CHECKMATE : V_CHECK;
                else            verdict_d = w_blocked ? V_STALEMATE : V_SAFE;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        probe_req  = 1'b0;
        probe_move = 14'd0;
        case (state_q)
            S_SELF: begin
                probe_req  = 1'b1;
                probe_move = {side_q, 1'b0, king_q, king_q};
            end
            S_REQ: begin
                probe_req  = 1'b1;
                probe_move = {side_q, 1'b0, w_dest_file, w_dest_rank, king_q};
            end
            default: ;
        endcase
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    assign verdict    = verdict_q;
    assign inCheck    = in_check_q;
    assign escapeMask = mask_q;
    assign timeoutErr = timeout_q;

endmodule
`default_nettype wire
